// File: rtl/pulse_seq_pkg.sv
// Shared types and default widths for the pulse sequencer.
package pulse_seq_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_NUM_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    // Scan requesters cyclically from the pointer and keep only the first hit
    always_comb begin
        logic found_s;
        logic hit_s;
        int   idx_s;
        grant   = {N_REQ{1'b0}};
        found_s = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            idx_s        = (int'(ptr) + off) % N_REQ;
            hit_s        = req[idx_s] & ~found_s;
            grant[idx_s] = hit_s;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/pulse_sequencer.sv
// Arbitrated pulse-train generator. Defining PULSE_SEQ_ABORT_EN adds abort_i,
// which ends a running train early through the DONE state.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef PULSE_SEQ_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] grant_o,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [NUM_W-1:0] num_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [PTR_W-1:0]   ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   width_r;
    logic [CNT_W-1:0]   low_r;
    logic [NUM_W-1:0]   pulses_r;

    logic [N_REQ-1:0]   arb_grant_s;
    logic [PTR_W-1:0]   win_idx_s;
    logic [PTR_W-1:0]   ptr_next_s;
    logic [CNT_W-1:0]   width_eff_s;
    logic [CNT_W-1:0]   low_eff_s;
    logic [NUM_W-1:0]   num_eff_s;
    logic               abort_s;

`ifdef PULSE_SEQ_ABORT_EN
    assign abort_s = abort_i;
`else
    assign abort_s = 1'b0;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req_i),
        .ptr   (ptr_r),
        .grant (arb_grant_s)
    );

    // Zero width/count mean one; the low phase is never shorter than one cycle
    always_comb begin
        width_eff_s = (width_i == {CNT_W{1'b0}}) ? CNT_ONE : width_i;
        num_eff_s   = (num_i == {NUM_W{1'b0}}) ? NUM_ONE : num_i;
        if (period_i > width_eff_s) begin
            low_eff_s = period_i - width_eff_s;
        end else begin
            low_eff_s = CNT_ONE;
        end
    end

    // Encode the one-hot winner and compute the pointer just past it
    always_comb begin
        win_idx_s = {PTR_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            win_idx_s = win_idx_s | ({PTR_W{arb_grant_s[i]}} & PTR_W'(i));
        end
        ptr_next_s = (win_idx_s == PTR_W'(N_REQ - 1)) ? {PTR_W{1'b0}} : win_idx_s + 1'b1;
    end

    // Train FSM; all outputs are registered alongside the state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            width_r  <= {CNT_W{1'b0}};
            low_r    <= {CNT_W{1'b0}};
            pulses_r <= {NUM_W{1'b0}};
            grant_o  <= {N_REQ{1'b0}};
            pulse_o  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (|req_i) begin
                        state_r  <= ST_HIGH;
                        grant_o  <= arb_grant_s;
                        ptr_r    <= ptr_next_s;
                        width_r  <= width_eff_s;
                        low_r    <= low_eff_s;
                        cnt_r    <= width_eff_s;
                        pulses_r <= num_eff_s;
                        pulse_o  <= 1'b1;
                        busy_o   <= 1'b1;
                    end else begin
                        grant_o <= {N_REQ{1'b0}};
                        pulse_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (abort_s) begin
                        state_r <= ST_DONE;
                        pulse_o <= 1'b0;
                        done_o  <= 1'b1;
                    end else if (cnt_r == CNT_ONE) begin
                        state_r <= ST_LOW;
                        pulse_o <= 1'b0;
                        cnt_r   <= low_r;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (abort_s) begin
                        state_r <= ST_DONE;
                        done_o  <= 1'b1;
                    end else if (cnt_r != CNT_ONE) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (pulses_r == NUM_ONE) begin
                        state_r <= ST_DONE;
                        done_o  <= 1'b1;
                    end else begin
                        state_r  <= ST_HIGH;
                        pulse_o  <= 1'b1;
                        cnt_r    <= width_r;
                        pulses_r <= pulses_r - NUM_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    grant_o <= {N_REQ{1'b0}};
                    pulse_o <= 1'b0;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_o <= {N_REQ{1'b0}};
                    pulse_o <= 1'b0;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer; directed cases plus randomized trains
// compared against a waveform model built from the train parameters.
module tb_pulse_sequencer;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [CW-1:0] width;
    logic [CW-1:0] period;
    logic [NW-1:0] num;
    logic          pulse;
    logic          busy;
    logic          done;
`ifdef PULSE_SEQ_ABORT_EN
    logic          abort;
`endif

    int            n_cmp = 0;
    int            n_fail = 0;
    int            ptr_m = 0;
    logic [N-1:0]  first_grant;
    logic [63:0]   cap;
    int            cap_len;
    int            cap_ones;

    always #5 clk = ~clk;

    pulse_sequencer #(.N_REQ(N), .CNT_W(CW), .NUM_W(NW)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
`ifdef PULSE_SEQ_ABORT_EN
        .abort_i  (abort),
`endif
        .req_i    (req),
        .grant_o  (grant),
        .width_i  (width),
        .period_i (period),
        .num_i    (num),
        .pulse_o  (pulse),
        .busy_o   (busy),
        .done_o   (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {25'd0, pulse, busy, done, grant};
    endfunction

    function automatic logic [31:0] mk(input bit p, input bit b, input bit d, input logic [N-1:0] g);
        return {25'd0, p, b, d, g};
    endfunction

    // Round-robin reference: first requester at or after the model pointer
    function automatic int rr_pick(input logic [N-1:0] r);
        for (int off = 0; off < N; off++) begin
            if (r[(ptr_m + off) % N]) return (ptr_m + off) % N;
        end
        return 0;
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        tick;
        tick;
        check("reset", outs(), 32'd0);
        rst = 1'b0;
        ptr_m = 0;
    endtask

    // Launch one train from IDLE and check every cycle through the idle cycle after DONE
    task automatic run_train(input string tag, input logic [N-1:0] r, input bit keep,
                             input int w, input int p, input int n,
                             input bit mid, input int mw);
        int           we;
        int           le;
        int           ne;
        int           win;
        logic [N-1:0] g;
        bit           q[$];
        we = (w == 0) ? 1 : w;
        ne = (n == 0) ? 1 : n;
        le = (p > we) ? p - we : 1;
        win = rr_pick(r);
        g = '0;
        g[win] = 1'b1;
        ptr_m = (win + 1) % N;
        for (int k = 0; k < ne; k++) begin
            repeat (we) q.push_back(1'b1);
            repeat (le) q.push_back(1'b0);
        end
        req    = r;
        width  = w[CW-1:0];
        period = p[CW-1:0];
        num    = n[NW-1:0];
        cap = '0;
        cap_len = 0;
        cap_ones = 0;
        for (int i = 0; i < q.size(); i++) begin
            tick;
            if (i == 0) begin
                first_grant = grant;
                if (!keep) req = '0;
                if (mid) begin
                    width  = mw[CW-1:0];
                    period = CW'($urandom_range(0, 20));
                    num    = NW'($urandom_range(0, 9));
                end
            end
            cap = {cap[62:0], pulse};
            cap_len++;
            if (pulse === 1'b1) cap_ones++;
            check(tag, outs(), mk(q[i], 1'b1, 1'b0, g));
        end
        tick;
        check({tag, "_done"}, outs(), mk(1'b0, 1'b1, 1'b1, g));
        tick;
        check({tag, "_idle"}, outs(), 32'd0);
    endtask

    initial begin
        logic [N-1:0] exp_g [5];
        logic [9:0]   pat31;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        pat31 = 10'b1110011100;
        rst = 1'b0;
        req = '0;
        width = '0;
        period = '0;
        num = '0;
`ifdef PULSE_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        do_reset();

        // Basic two-pulse train
        run_train("basic", 4'b0001, 1'b0, 3, 5, 2, 1'b0, 0);
        check("basic_len", 32'(cap_len), 32'd10);
        check("basic_pat", {22'd0, cap[9:0]}, {22'd0, pat31});

        // Held all-request: rotating grants
        do_reset();
        for (int t = 0; t < 5; t++) begin
            run_train("rr", 4'b1111, 1'b1, 1, 2, 1, 1'b0, 0);
            check("rr_grant", {28'd0, first_grant}, {28'd0, exp_g[t]});
        end
        req = '0;

        // Zero parameters behave as one-cycle high, one-cycle low, single pulse
        run_train("zero", 4'b0100, 1'b0, 0, 0, 0, 1'b0, 0);
        check("zero_len", 32'(cap_len), 32'd2);
        check("zero_pat", {30'd0, cap[1:0]}, 32'd2);

        // Width change mid-train must not matter
        run_train("latch", 4'b1000, 1'b0, 4, 7, 3, 1'b1, 9);
        check("latch_ones", 32'(cap_ones), 32'd12);

        // Reset during the second high cycle of a long pulse
        req = 4'b0001;
        width = 16'd10;
        period = 16'd12;
        num = 8'd1;
        tick;
        check("rst_h1_busy", {31'd0, busy}, 32'd1);
        req = '0;
        tick;
        check("rst_h2_pulse", {31'd0, pulse}, 32'd1);
        rst = 1'b1;
        tick;
        check("rst_mid", outs(), 32'd0);
        rst = 1'b0;
        ptr_m = 0;
        tick;
        check("rst_quiet1", outs(), 32'd0);
        tick;
        check("rst_quiet2", outs(), 32'd0);
        run_train("rst_after", 4'b1111, 1'b0, 2, 3, 1, 1'b0, 0);
        check("rst_after_grant", {28'd0, first_grant}, 32'd1);

        // Randomized trains
        for (int t = 0; t < 25; t++) begin
            run_train("rand", N'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 9)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 15)));
            req = '0;
        end

`ifdef PULSE_SEQ_ABORT_EN
        begin
            int           win;
            logic [N-1:0] g;
            int           highs;
            win = rr_pick(4'b0010);
            g = '0;
            g[win] = 1'b1;
            ptr_m = (win + 1) % N;
            req = 4'b0010;
            width = 16'd2;
            period = 16'd4;
            num = 8'd5;
            highs = 0;
            tick;
            if (pulse === 1'b1) highs++;
            check("abort_h1", outs(), mk(1'b1, 1'b1, 1'b0, g));
            req = '0;
            tick;
            if (pulse === 1'b1) highs++;
            check("abort_h2", outs(), mk(1'b1, 1'b1, 1'b0, g));
            tick;
            check("abort_l1", outs(), mk(1'b0, 1'b1, 1'b0, g));
            abort = 1'b1;
            tick;
            abort = 1'b0;
            check("abort_done", outs(), mk(1'b0, 1'b1, 1'b1, g));
            tick;
            check("abort_idle", outs(), 32'd0);
            check("abort_highs", 32'(highs), 32'd2);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_sequencer.md
PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of trigger requesters.
REQ-002 SHALL have parameter CNT_W, default 16, width of the width/period counters.
REQ-003 SHALL have parameter NUM_W, default 8, width of the pulse-count field.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_i  in  N_REQ  level request per requester.
REQ-007 SHALL have port grant_o  out  N_REQ  one-hot grant, held for the whole train.
REQ-008 SHALL have port width_i  in  CNT_W  high-phase length in cycles.
REQ-009 SHALL have port period_i  in  CNT_W  full pulse period in cycles.
REQ-010 SHALL have port num_i  in  NUM_W  pulses per train.
REQ-011 SHALL have port pulse_o  out  1  registered pulse output.
REQ-012 SHALL have port busy_o  out  1  high from grant until DONE inclusive.
REQ-013 SHALL have port done_o  out  1  one-cycle strobe at train end.

Function
REQ-014 SHALL implement the FSM states IDLE, HIGH, LOW and DONE.
REQ-015 In IDLE with any req_i bit set at cycle k, SHALL select a winner round-robin and enter HIGH; grant_o, busy_o and pulse_o SHALL be high at cycle k+1.
REQ-016 SHALL start the round-robin pointer at requester 0 after reset; after serving requester i, requester i+1 (mod N_REQ) SHALL have highest priority.
REQ-017 SHALL latch width_i, period_i and num_i at grant; input changes during a train SHALL have no effect.
REQ-018 SHALL treat width_i=0 as 1 and num_i=0 as 1.
REQ-019 SHALL hold the low phase for max(period-width,1) cycles, so period_i<=width_i gives exactly 1 low cycle.
REQ-020 SHALL remain in HIGH for width cycles with pulse_o=1, then in LOW for the low-phase length with pulse_o=0, repeating num times.
REQ-021 After the LOW phase of the last pulse, SHALL spend one cycle in DONE with done_o=1, busy_o=1, grant_o still asserted and pulse_o=0, then return to IDLE.
REQ-022 SHALL grant no requester during the DONE cycle; the earliest next grant SHALL be the cycle after IDLE is re-entered.
REQ-023 SHALL ignore requests arriving during a train without queueing them; a requester SHALL hold req_i until it is granted.
REQ-024 SHALL keep counter arithmetic unsigned CNT_W/NUM_W bits with no wrap; counters SHALL count down to 1 and never underflow.

Reset
REQ-025 While rst_i=1 at a clock edge, SHALL force state to IDLE and drive pulse_o, busy_o, done_o and grant_o to 0, and the RR pointer to 0.
REQ-026 Reset mid-train SHALL abandon the train with no done_o strobe.

Configuration
REQ-027 With PULSE_SEQ_ABORT_EN defined, SHALL add port abort_i (in, 1); abort_i=1 in HIGH or LOW SHALL move the block to DONE on the next cycle, with pulse_o=0 and done_o=1.
REQ-028 Without PULSE_SEQ_ABORT_EN, abort_i SHALL NOT exist and a train SHALL always run to completion.

Structure
REQ-029 A shared package pulse_seq_pkg SHALL hold the FSM state enum and the default widths CNT_W=16 and NUM_W=8.
REQ-030 The round-robin arbiter SHALL be a sub-module rr_arbiter (req, pointer -> one-hot grant), purely combinational with the pointer register in the parent.

Verification
REQ-031 The bench SHALL check: req_i=0001, width=3, period=5, num=2 -> pulse_o pattern 1,1,1,0,0,1,1,1,0,0 starting the cycle after req, then done_o one cycle, busy_o low the next cycle.
REQ-032 The bench SHALL check: req_i=1111 held, num=1, width=1, period=2 -> grants in order 0001, 0010, 0100, 1000, 0001.
REQ-033 The bench SHALL check: width=0, period=0, num=0 -> one 1-cycle high, one 1-cycle low, then done_o.
REQ-034 The bench SHALL check: width_i changed from 4 to 9 mid-train -> all pulses remain 4 cycles high.
REQ-035 The bench SHALL check: rst_i asserted in the 2nd HIGH cycle of width=10 -> next cycle all outputs 0, no done_o; a req two cycles after reset release is granted to requester 0 if req_i=1111.
REQ-036 With PULSE_SEQ_ABORT_EN defined, the bench SHALL check: abort_i during LOW of pulse 1 of num=5 -> DONE the next cycle, exactly 1 pulse emitted.
